// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch and IF/ID buffer with stall, flush and halt; FETCH_STALL_CNT_EN adds stall_cnt
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          PC_INC    = 2,
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter logic [3:0]  HALT_OP   = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pcenable,
   input  logic        fetchbuffenable,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pcplus,
   output logic        ifid_valid,
   output logic        halted
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);
   typedef enum logic {RUN, HALT} state_t;
   localparam logic [15:0] INC = 16'(PC_INC);
   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d, instr_q, instr_d, pcplus_q, pcplus_d, pc_next;
   logic        valid_q, valid_d, load_halt;
   assign pc_next   = pc_q + INC;
   assign load_halt = fetchbuffenable && imem_data[15:12] == HALT_OP;
   // next state: branch flush beats halt hold, which beats stall and normal fetch
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pcplus_d = pcplus_q;
      valid_d  = valid_q;
      if (branch_taken) begin
         state_d = RUN;
         pc_d    = branch_target;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (state_q == HALT) begin
         instr_d = fetchbuffenable ? NOP_INSTR : instr_q;
         valid_d = fetchbuffenable ? 1'b0 : valid_q;
      end else begin
         state_d  = load_halt ? HALT : RUN;
         pc_d     = (pcenable && !load_halt) ? pc_next : pc_q;
         instr_d  = fetchbuffenable ? imem_data : instr_q;
         pcplus_d = fetchbuffenable ? pc_next : pcplus_q;
         valid_d  = fetchbuffenable ? 1'b1 : valid_q;
      end
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pcplus_q <= 16'h0000;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pcplus_q <= pcplus_d;
         valid_q  <= valid_d;
      end
   end
   assign imem_addr   = pc_q;
   assign ifid_instr  = instr_q;
   assign ifid_pcplus = pcplus_q;
   assign ifid_valid  = valid_q;
   assign halted      = state_q == HALT;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   // saturating count of PC-stalled cycles while running
   always_comb
      stall_cnt_d = (state_q == RUN && !pcenable && !branch_taken && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   // counter register
   always_ff @(posedge clk) begin
      if (!rst_n) stall_cnt_q <= 16'h0000;
      else        stall_cnt_q <= stall_cnt_d;
   end
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized check of fetch_stage against a behavioural model
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst_n, pce, fbe, br;
   logic [15:0] tgt, imem_addr, imem_data, ifid_instr, ifid_pcplus;
   logic        ifid_valid, halted;
   logic [15:0] mem [256];
   int          checks = 0, errors = 0;
   logic [15:0] m_pc, m_instr, m_pcplus, m_cnt;
   logic        m_valid, m_halt;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif
   always #5 clk = ~clk;
   assign imem_data = mem[imem_addr[8:1]];
   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .pcenable(pce), .fetchbuffenable(fbe),
      .branch_taken(br), .branch_target(tgt), .imem_addr(imem_addr),
      .imem_data(imem_data), .ifid_instr(ifid_instr), .ifid_pcplus(ifid_pcplus),
      .ifid_valid(ifid_valid), .halted(halted)
`ifdef FETCH_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   // behavioural model of one clock edge, from the current inputs
   task automatic model_step();
      logic [15:0] word;
      logic        halt_load;
      word = mem[m_pc[8:1]];
      if (!rst_n) begin
         m_pc = 16'h0000; m_instr = 16'h0000; m_pcplus = 16'h0000;
         m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0000;
      end else if (br) begin
         m_pc = tgt; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
      end else if (m_halt) begin
         if (fbe) begin m_instr = 16'h0000; m_valid = 1'b0; end
      end else begin
         if (!pce && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
         halt_load = fbe && word[15:12] == 4'hF;
         if (fbe) begin m_instr = word; m_pcplus = m_pc + 16'd2; m_valid = 1'b1; end
         if (pce && !halt_load) m_pc = m_pc + 16'd2;
         m_halt = halt_load;
      end
   endtask
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("imem_addr", imem_addr, m_pc);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_pcplus", ifid_pcplus, m_pcplus);
      check("ifid_valid", {15'b0, ifid_valid}, {15'b0, m_valid});
      check("halted", {15'b0, halted}, {15'b0, m_halt});
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_cnt);
`endif
      #3;
   endtask
   task automatic drive(input logic r, input logic en, input logic b, input logic [15:0] t);
      rst_n = r; pce = en; fbe = en; br = b; tgt = t;
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hEFFF));
      mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h0A0A; mem[3] = 16'h3456; mem[4] = 16'hF000;
      m_pc = 0; m_instr = 0; m_pcplus = 0; m_cnt = 0; m_valid = 0; m_halt = 0;
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      @(negedge clk);
      cycle(); cycle();
      check("rst_addr", imem_addr, 16'h0000);
      check("rst_valid", {15'b0, ifid_valid}, 16'h0000);
      rst_n = 1'b1;
      cycle();
      check("run1_instr", ifid_instr, 16'h1234);
      check("run1_pcplus", ifid_pcplus, 16'h0002);
      cycle();
      check("run2_instr", ifid_instr, 16'h2345);
      check("run2_pcplus", ifid_pcplus, 16'h0004);
      check("run2_addr", imem_addr, 16'h0004);
      cycle();
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      repeat (3) cycle();
      check("stall_addr", imem_addr, 16'h0006);
      check("stall_instr", ifid_instr, 16'h0A0A);
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt3", stall_cnt, 16'h0003);
`endif
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      cycle();
      check("release_instr", ifid_instr, 16'h3456);
      check("release_addr", imem_addr, 16'h0008);
      cycle();
      check("halt_instr", ifid_instr, 16'hF000);
      check("halt_valid", {15'b0, ifid_valid}, 16'h0001);
      check("halt_flag", {15'b0, halted}, 16'h0001);
      check("halt_addr", imem_addr, 16'h0008);
      cycle();
      check("halt_bubble", {15'b0, ifid_valid}, 16'h0000);
      repeat (5) cycle();
      check("halt_hold_addr", imem_addr, 16'h0008);
      drive(1'b1, 1'b1, 1'b1, 16'h0010);
      cycle();
      check("squash_halted", {15'b0, halted}, 16'h0000);
      check("squash_addr", imem_addr, 16'h0010);
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      cycle(); cycle();
      check("resume_addr", imem_addr, 16'h0014);
      drive(1'b1, 1'b0, 1'b1, 16'h0040);
      cycle();
      check("brstall_addr", imem_addr, 16'h0040);
      check("brstall_valid", {15'b0, ifid_valid}, 16'h0000);
      check("brstall_instr", ifid_instr, 16'h0000);
      drive(1'b1, 1'b1, 1'b1, 16'hFFFE);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      cycle();
      check("wrap_addr", imem_addr, 16'h0000);
      drive(1'b1, 1'b1, 1'b1, 16'h0008);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      cycle();
      check("halt2_flag", {15'b0, halted}, 16'h0001);
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      cycle();
      check("rsthalt_addr", imem_addr, 16'h0000);
      check("rsthalt_halted", {15'b0, halted}, 16'h0000);
      check("rsthalt_valid", {15'b0, ifid_valid}, 16'h0000);
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 7) == 0) ? {4'hF, 12'($urandom)} : 16'($urandom);
      for (int n = 0; n < 2000; n++) begin
         if (n % 50 == 0) mem[$urandom_range(0, 255)] = 16'($urandom);
         drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) >= 3, $urandom_range(0, 9) == 0,
               ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 16'h01FF)) & 16'hFFFE);
         cycle();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID fetch buffer of the 5-stage 16-bit pipeline.
- Sits directly upstream of the decode stage. Consumes `pcenable` and `fetchbuffenable` from the hazard detection unit (`hazdet`), and branch redirects from EX.
- Owns the program counter, drives the instruction memory address, and registers the fetched instruction for decode. Handles stall, flush and halt.

Parameters:
- `RESET_PC`, `16'h0000`, PC value loaded on reset.
- `PC_INC`, `2`, PC increment per fetch (byte-addressed, 16-bit instructions).
- `NOP_INSTR`, `16'h0000`, bubble pattern written into the buffer on reset, flush or halt.
- `HALT_OP`, `4'hF`, opcode (`instr[15:12]`) that halts fetch.

Ports:
- `clk`  input  1  system clock, all state updates on posedge.
- `rst_n`  input  1  synchronous active-low reset.
- `pcenable`  input  1  from `hazdet`; 1 = PC may update, 0 = PC holds.
- `fetchbuffenable`  input  1  from `hazdet`; 1 = IF/ID buffer may load, 0 = buffer holds.
- `branch_taken`  input  1  from EX; 1 = redirect PC and flush buffer this cycle.
- `branch_target`  input  16  redirect address, valid when `branch_taken`=1.
- `imem_addr`  output  16  instruction memory address (combinational from PC register).
- `imem_data`  input  16  instruction word returned combinationally for `imem_addr`.
- `ifid_instr`  output  16  registered instruction to decode.
- `ifid_pcplus`  output  16  registered PC+`PC_INC` of that instruction, for link and branch offsets.
- `ifid_valid`  output  1  1 = `ifid_instr` is a real instruction, 0 = bubble.
- `halted`  output  1  1 while in HALT state.

Behaviour:
- **Reset** (`rst_n`=0 at posedge):
  - `pc`=`RESET_PC`, `ifid_instr`=`NOP_INSTR`, `ifid_pcplus`=0, `ifid_valid`=0, `halted`=0, state=RUN.
  - Reset overrides every other input, including mid-stall and mid-halt.
- **`imem_addr`** = `pc` at all times; fetch latency is 0 cycles to `imem_data`, 1 cycle to `ifid_instr`.
- **State machine:** two states, RUN and HALT. Priority per cycle: reset > `branch_taken` > HALT hold > stall enables > normal fetch.
- **RUN, `branch_taken`=1:**
  - `pc`<=`branch_target`; buffer<=`NOP_INSTR`, `ifid_valid`<=0.
  - Applies regardless of `pcenable`/`fetchbuffenable`.
- **RUN, no branch:**
  - If `pcenable`=1: `pc`<=`pc`+`PC_INC` (16-bit wrap, `16'hFFFE`+2 -> `16'h0000`); else `pc` holds.
  - If `fetchbuffenable`=1: `ifid_instr`<=`imem_data`, `ifid_pcplus`<=`pc`+`PC_INC`, `ifid_valid`<=1; else all three hold.
  - The two enables act independently. `hazdet` only asserts them together (1/1 run, 0/0 stall); the other combinations are legal but not exercised.
- **RUN -> HALT:**
  - Taken when the buffer loads an instruction with `imem_data[15:12]`=`HALT_OP` and no branch that cycle.
  - The halt instruction itself passes to decode with `ifid_valid`=1.
  - `pc` does not advance past the halt: `pc` holds on the loading edge even if `pcenable`=1.
- **HALT:**
  - `pc` holds, `halted`=1.
  - When `fetchbuffenable`=1: buffer<=`NOP_INSTR`, `ifid_valid`<=0; when 0: buffer holds (so the halt instruction survives a stall).
  - `branch_taken`=1 -> RUN, `pc`<=`branch_target`, buffer flushed, `halted`<=0 next cycle. This squashes a halt fetched in a branch shadow.
- **Simultaneous events:**
  - Branch with stall (enables 0): the branch wins.
  - Halt opcode on `imem_data` while `fetchbuffenable`=0: not loaded, no transition.
- **X inputs:** no requirement.

Optional Feature:
- Macro: `FETCH_STALL_CNT_EN`.
- **With the macro:**
  - Adds output `stall_cnt` [15:0]: a saturating count of cycles in RUN with `pcenable`=0 and `branch_taken`=0.
  - Cleared by reset; holds at `16'hFFFF` when saturated; does not count in HALT.
- **Without the macro:** the port and counter are absent; all other behaviour is identical.

Test Plan:
- **Reset then run:** `rst_n`=0 for 2 cycles, then 1; enables=1/1; imem returns `16'h1234`,`16'h2345` for addresses 0, 2 -> after reset `imem_addr`=0, `ifid_valid`=0; next edges give `ifid_instr`=`16'h1234`/`ifid_pcplus`=2, then `16'h2345`/4, with `pc`=4.
- **Stall:** at `pc`=6, drive enables 0/0 for 3 cycles -> `imem_addr` stays 6 and the `ifid_*` outputs are unchanged. Release -> the instruction at 6 loads, `pc`=8. With `FETCH_STALL_CNT_EN`, `stall_cnt`=3.
- **Branch during stall:** enables 0/0, `branch_taken`=1, `branch_target`=`16'h0040` -> next cycle `imem_addr`=`16'h0040`, `ifid_valid`=0, `ifid_instr`=`NOP_INSTR`.
- **Halt:** imem at 8 = `16'hF000`, enables 1/1 -> `ifid_instr`=`16'hF000`, `ifid_valid`=1, `halted`=1, `pc` stays 8. The next cycle yields `ifid_valid`=0; `pc` stays 8 for 5 more cycles.
- **Halt squash:** in HALT, `branch_taken`=1, target `16'h0010` -> `halted`=0, `pc`=`16'h0010`, and normal fetch resumes.
- **Wrap and reset mid-halt:**
  - Branch to `16'hFFFE` with enables 1/1 -> `pc`=`16'h0000` after one fetch.
  - Halt, then `rst_n`=0 for one cycle -> `pc`=`RESET_PC`, `halted`=0, `ifid_valid`=0.
